reset_seq: RTL
==============

// Module: reset_seq
// PURPOSE
//  Board-level reset sequencer feeding the top level's reset and clock generator. Combines the
//  async button reset, host serial RTS line, software reboot request (cfg[7]) and PLL lock.
//  Produces a sequenced PLL reset and a stretched core reset. Runs on the free-running board
//  oscillator so it keeps counting while the PLL is held in reset.
// PARAMETERS
//  PLL_RES_CYCLES  16          clk_in cycles pll_res is held high per PLL reset attempt
//  LOCK_TIMEOUT    10_000_000  clk_in cycles to wait for lock before retrying PLL reset (100 ms)
//  HOLD_CYCLES     1_000_000   clk_in cycles core_res is held after a trigger (10 ms)
//  - all three: 1 .. 2^24-1; one shared 24-bit down-counter
// PORTS
//  clk_in     in   1  board oscillator (100 MHz), free-running
//  res        in   1  asynchronous, active-high reset (power-on / board button)
//  rts_n      in   1  raw host RTS, active-low, asynchronous
//  reboot     in   1  software reboot request (cfg[7]), clock-domain-crossed; rising edge = request
//  pll_locked in   1  lock from clock generator, asynchronous
//  pll_res    out  1  active-high reset to clock generator
//  core_res   out  1  active-high core reset (top resynchronises into clk_cog)
//  rst_cause  out  2  cause of last core reset: 0 POR, 1 RTS, 2 SW reboot, 3 lock loss/timeout
// BEHAVIOUR
//  - rts_n, reboot, pll_locked: each through a 2-flop synchroniser, then 1 registered copy for edges
//  - res high: state=S_PLLRST, cnt=PLL_RES_CYCLES-1, pll_res=1, core_res=1, rst_cause=0, edge regs cleared
//  - pll_res  = (state==S_PLLRST); core_res = (state!=S_RUN); both decoded from state register only
//  - S_PLLRST: cnt decrements; at cnt==0 -> S_WAITLOCK, cnt=LOCK_TIMEOUT-1
//  - S_WAITLOCK: lock_s high -> S_HOLD, cnt=HOLD_CYCLES-1; else cnt==0 -> S_PLLRST, rst_cause=3
//  - S_HOLD: lock_s low -> S_PLLRST, cause 3; RTS trigger -> reload cnt=HOLD_CYCLES-1, stay;
//            cnt==0 -> S_RUN (core_res low exactly HOLD_CYCLES cycles after last reload)
//  - S_RUN: priority lock loss (-> S_PLLRST, cause 3) > RTS trigger (-> S_HOLD, cause 1)
//           > reboot rising edge (-> S_HOLD, cause 2); reload cnt=HOLD_CYCLES-1
//  - reboot edges outside S_RUN are ignored. Reboot held high across S_HOLD does not retrigger.
//  - Latency: rts_n fall -> core_res high at 3rd clk_in edge (2 sync + 1 edge detect/state update)
//  - res asserted mid-sequence: immediate async return to reset values, cause reverts to 0
//  - rst_cause updated on the same edge the transition is taken; holds value otherwise
// CONFIGURATION
//  - RESET_RTS_EDGE_EN defined: RTS trigger = falling edge of synchronised rts_n (Prop Plug
//    capacitor emulation); rts_n held low gives one HOLD_CYCLES pulse only
//  - undefined: RTS trigger = level rts_s==0; counter reloaded each cycle while low;
//    core_res releases HOLD_CYCLES cycles after rts_n returns high
// STRUCTURE
//  - package reset_seq_pkg: typedef enum logic [1:0] {S_PLLRST,S_WAITLOCK,S_HOLD,S_RUN};
//    cause constants CAUSE_POR/RTS/SW/LOCK; CNT_W=24
//  - sub-module sync2 (2-flop synchroniser, async reset value parameter); instanced 3x
//    rts_n resets to 1, others to 0
// TESTING (PLL_RES_CYCLES=4, LOCK_TIMEOUT=20, HOLD_CYCLES=8)
//  - POR: res pulse, pll_locked=1 -> pll_res high 4 cycles, then core_res low after 2 sync + 8 hold; cause=0
//  - No lock: pll_locked=0 -> pll_res pulses 4 cycles every 24 cycles; core_res stays 1; cause=3
//  - RTS in S_RUN (edge mode): rts_n low 50 cycles -> core_res high 3rd edge, low 8 later; cause=1
//  - RTS level mode: same stimulus -> core_res high until 8 cycles after rts_n rises (+sync)
//  - reboot rising and rts_n fall same cycle in S_RUN -> cause=1; reboot alone -> cause=2, 8-cycle hold
//  - pll_locked drop during S_HOLD -> immediate S_PLLRST, pll_res=1, cause=3; res mid-HOLD -> reset values

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the board reset sequencer.
// States, reset-cause encodings and the down-counter width.
package reset_seq_pkg;

    localparam int CNT_W = 24;

    typedef enum logic [1:0] {
        S_PLLRST   = 2'd0,
        S_WAITLOCK = 2'd1,
        S_HOLD     = 2'd2,
        S_RUN      = 2'd3
    } state_t;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_POR  = 2'd0;
    localparam cause_t CAUSE_RTS  = 2'd1;
    localparam cause_t CAUSE_SW   = 2'd2;
    localparam cause_t CAUSE_LOCK = 2'd3;

    // Counter reload value for a phase lasting 'cycles' clocks (counts down to zero).
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/reset_seq_sync2.sv
// Two-flop synchroniser with a configurable asynchronous reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= RST_VAL;
            q       <= RST_VAL;
        end else begin
            sync_p0 <= d;
            q       <= sync_p0;
        end
    end

endmodule

// File: rtl/reset_seq.sv
// Board reset sequencer: sequences PLL reset, waits for lock and stretches the core reset.
// Build option RESET_RTS_EDGE_EN: RTS triggers on the falling edge instead of the low level.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int unsigned PLL_RES_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 10_000_000,
    parameter int unsigned HOLD_CYCLES    = 1_000_000
) (
    input  logic       clk_in,
    input  logic       res,
    input  logic       rts_n,
    input  logic       reboot,
    input  logic       pll_locked,
    output logic       pll_res,
    output logic       core_res,
    output logic [1:0] rst_cause
);

    logic             rts_s;
    logic             reboot_s;
    logic             lock_s;
    logic             reboot_s_p1;
    logic             rts_trig;
    logic             reboot_rise;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // ---- stage 0/1: synchronise asynchronous inputs ----
    sync2 #(.RST_VAL(1'b1)) u_sync_rts (
        .clk (clk_in),
        .rst (res),
        .d   (rts_n),
        .q   (rts_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_reboot (
        .clk (clk_in),
        .rst (res),
        .d   (reboot),
        .q   (reboot_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_lock (
        .clk (clk_in),
        .rst (res),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // ---- stage 2: edge detection ----
    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            reboot_s_p1 <= 1'b0;
        end else begin
            reboot_s_p1 <= reboot_s;
        end
    end

    assign reboot_rise = reboot_s & ~reboot_s_p1;

`ifdef RESET_RTS_EDGE_EN
    logic rts_s_p1;

    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            rts_s_p1 <= 1'b1;
        end else begin
            rts_s_p1 <= rts_s;
        end
    end

    // A held-low RTS yields a single hold period, like the Prop Plug's series capacitor.
    assign rts_trig = rts_s_p1 & ~rts_s;
`else
    assign rts_trig = ~rts_s;
`endif

    // ---- stage 3: sequencer state and shared down-counter ----
    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            state     <= S_PLLRST;
            cnt       <= cnt_load(PLL_RES_CYCLES);
            rst_cause <= CAUSE_POR;
        end else begin
            case (state)
                S_PLLRST: begin
                    if (cnt == '0) begin
                        state <= S_WAITLOCK;
                        cnt   <= cnt_load(LOCK_TIMEOUT);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WAITLOCK: begin
                    if (lock_s) begin
                        state <= S_HOLD;
                        cnt   <= cnt_load(HOLD_CYCLES);
                    end else if (cnt == '0) begin
                        state     <= S_PLLRST;
                        cnt       <= cnt_load(PLL_RES_CYCLES);
                        rst_cause <= CAUSE_LOCK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (!lock_s) begin
                        state     <= S_PLLRST;
                        cnt       <= cnt_load(PLL_RES_CYCLES);
                        rst_cause <= CAUSE_LOCK;
                    end else if (rts_trig) begin
                        cnt <= cnt_load(HOLD_CYCLES);
                    end else if (cnt == '0) begin
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // Reboot edges are only honoured here; one seen earlier is simply dropped.
                    if (!lock_s) begin
                        state     <= S_PLLRST;
                        cnt       <= cnt_load(PLL_RES_CYCLES);
                        rst_cause <= CAUSE_LOCK;
                    end else if (rts_trig) begin
                        state     <= S_HOLD;
                        cnt       <= cnt_load(HOLD_CYCLES);
                        rst_cause <= CAUSE_RTS;
                    end else if (reboot_rise) begin
                        state     <= S_HOLD;
                        cnt       <= cnt_load(HOLD_CYCLES);
                        rst_cause <= CAUSE_SW;
                    end
                end
                default: begin
                    state <= S_PLLRST;
                    cnt   <= cnt_load(PLL_RES_CYCLES);
                end
            endcase
        end
    end

    assign pll_res  = (state == S_PLLRST);
    assign core_res = (state != S_RUN);

endmodule
